// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the unified-SRAM bus arbiter: FSM states, the
// full-word byte-enable pattern and the stall-vector bit positions that
// mark ownership of each port's result.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_IBUSY = 2'd1;
  localparam logic [1:0] ARB_DBUSY = 2'd2;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Stall-vector bits that hold the stage owning each port's result.
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_EX_MEM = 3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and the MEM-stage
// data port. Each access takes SRAM_LAT busy cycles followed by one mandatory
// idle (turnaround) cycle. A per-port done flag holds the captured result and
// blocks re-issue until the owning pipeline stage advances.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int SRAM_LAT = 2,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_stallreq_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SRAM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             i_done;
  logic             d_done;

  logic busy;
  logic complete;
  logic issue_d;
  logic issue_i;
  logic hold_if;
  logic hold_mem;

  // Only the two ownership bits of the stall vector matter here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:4], stall_i[2], stall_i[0]};

  assign hold_if  = stall_i[STALL_IF_ID];
  assign hold_mem = stall_i[STALL_EX_MEM];

  assign busy     = (state == ARB_IBUSY) || (state == ARB_DBUSY);
  assign complete = busy && (cnt == '0);

  // Data wins over fetch: it belongs to the older instruction, and a stalled
  // fetch keeps the pipeline from advancing, so fetch cannot starve.
  assign issue_d = (state == ARB_IDLE) && mem_ce_i && !d_done;
  assign issue_i = (state == ARB_IDLE) && !issue_d && if_ce_i && !i_done;

  // Stall until the completion cycle of this port's access, or while a
  // request has not been served yet; never during reset.
  assign if_stallreq_o  = !rst && if_ce_i && !i_done &&
                          !((state == ARB_IBUSY) && (cnt == '0));
  assign mem_stallreq_o = !rst && mem_ce_i && !d_done &&
                          !((state == ARB_DBUSY) && (cnt == '0));

  // FSM, wait counter, done flags and bus strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      cnt      <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      bus_ce_o <= 1'b0;
      bus_we_o <= 1'b0;
    end else begin
      // A done flag survives only while its owning stage is held; an
      // advancing stage consumes the result, even on the completion edge.
      if (!hold_if)  i_done <= 1'b0;
      if (!hold_mem) d_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (issue_d) begin
            bus_ce_o <= 1'b1;
            bus_we_o <= mem_we_i;
            cnt      <= CNT_LOAD;
            state    <= ARB_DBUSY;
          end else if (issue_i) begin
            bus_ce_o <= 1'b1;
            bus_we_o <= 1'b0;
            cnt      <= CNT_LOAD;
            state    <= ARB_IBUSY;
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            if (state == ARB_IBUSY) i_done <= hold_if;
            else                    d_done <= hold_mem;
            bus_ce_o <= 1'b0;
            bus_we_o <= 1'b0;
            state    <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Bus address/data/byte-enable latching and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      if_data_o  <= '0;
      mem_data_o <= '0;
    end else begin
      if (issue_d) begin
        bus_sel_o  <= mem_sel_i;
        bus_addr_o <= mem_addr_i;
        bus_data_o <= mem_data_i;
      end else if (issue_i) begin
        bus_sel_o  <= SEL_ALL;
        bus_addr_o <= if_addr_i;
        bus_data_o <= '0;
      end
      if (complete) begin
        if (state == ARB_IBUSY) if_data_o  <= bus_data_i;
        else                    mem_data_o <= bus_we_o ? 32'h0 : bus_data_i;
      end
    end
  end

endmodule
